// File: rtl/scan_display_pkg.sv
// rtl/scan_display_pkg.sv - shared constants and helpers for the scan display generator
package scan_display_pkg;

    // Segment patterns for hex digits 0..F, bit order g..a
    localparam logic [6:0] HEX7SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic int which_width(input int digits);
        return (digits > 1) ? $clog2(digits) : 1;
    endfunction

endpackage

// File: rtl/scan_display_gen_if.sv
// rtl/scan_display_gen_if.sv - display data inputs and scan outputs of scan_display_gen
interface scan_display_gen_if #(
    parameter int DIGITS      = 8,
    parameter int DIV_BITS    = 11,
    parameter int BRIGHT_BITS = 3
) ();
    import scan_display_pkg::*;

    localparam int WHICH_W = which_width(DIGITS);

    logic [4*DIGITS-1:0]    data;
    logic [DIGITS-1:0]      dp;
    logic [DIGITS-1:0]      blank;
    logic                   lz_suppress;
    logic [BRIGHT_BITS-1:0] bright;
    logic [WHICH_W-1:0]     which;
    logic [7:0]             seg;
    logic [3:0]             digit;
    logic [DIV_BITS-1:0]    count;
    logic                   frame_done;

    modport master (
        output data, dp, blank, lz_suppress, bright,
        input  which, seg, digit, count, frame_done
    );

    modport slave (
        input  data, dp, blank, lz_suppress, bright,
        output which, seg, digit, count, frame_done
    );

endinterface

// File: rtl/hex7seg_decoder.sv
// rtl/hex7seg_decoder.sv - combinational hex nibble to seven-segment lookup
module hex7seg_decoder
    import scan_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = HEX7SEG[nibble];

endmodule

// File: rtl/scan_display_gen.sv
// rtl/scan_display_gen.sv - multiplexed hex seven-segment scanner with frame-synchronous latching,
// leading-zero suppression, blanking and PWM brightness
module scan_display_gen
    import scan_display_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int DIV_BITS    = 11,
    parameter int BRIGHT_BITS = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    scan_display_gen_if.slave  bus
);

    localparam int WHICH_W = which_width(DIGITS);
    localparam logic [WHICH_W-1:0] LAST_IDX = WHICH_W'(DIGITS - 1);

    logic [DIV_BITS-1:0]   cnt;
    logic [WHICH_W-1:0]    idx;
    logic [4*DIGITS-1:0]   sh_data;
    logic [DIGITS-1:0]     sh_dp;
    logic [DIGITS-1:0]     sh_blank;
    logic                  load_pend;

    logic                  cnt_wrap;
    logic                  idx_wrap;
    logic [3:0]            nib;
    logic [6:0]            hex;
    logic [DIGITS-1:0]     zero_from;
    logic                  lz_dark;
    logic                  pwm_on;
    logic [7:0]            seg_next;

    assign cnt_wrap = (cnt == {DIV_BITS{1'b1}});
    assign idx_wrap = cnt_wrap && (idx == LAST_IDX);

    // Stage 0: scan counters and the frame shadow of the display inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            idx       <= '0;
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            load_pend <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            if (cnt_wrap) begin
                idx <= idx_wrap ? '0 : idx + 1'b1;
            end
            if (load_pend || idx_wrap) begin
                sh_data  <= bus.data;
                sh_dp    <= bus.dp;
                sh_blank <= bus.blank;
            end
            load_pend <= 1'b0;
        end
    end

    assign nib = sh_data[4*idx +: 4];

    hex7seg_decoder u_dec (
        .nibble (nib),
        .segs   (hex)
    );

    // zero_from[i] is set when nibble i and every higher nibble are zero
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (sh_data[4*DIGITS-1 -: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (sh_data[4*i +: 4] == 4'h0);
        end
    end

    assign lz_dark = bus.lz_suppress && (idx != '0) && zero_from[idx];
    assign pwm_on  = (cnt[DIV_BITS-1 -: BRIGHT_BITS] <= bus.bright);

    always_comb begin
        seg_next = {sh_dp[idx], hex};
        if (sh_blank[idx] || lz_dark || !pwm_on) begin
            seg_next = SEG_OFF;
        end
    end

    // Stage 1: all visible outputs come from the same stage-0 cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.which      <= '0;
            bus.count      <= '0;
            bus.digit      <= '0;
            bus.seg        <= SEG_OFF;
            bus.frame_done <= 1'b0;
        end else begin
            bus.which      <= idx;
            bus.count      <= cnt;
            bus.digit      <= nib;
            bus.seg        <= seg_next;
            bus.frame_done <= (idx == '0) && (bus.which == LAST_IDX);
        end
    end

endmodule

// File: tb/tb_scan_display_gen.sv
// tb/tb_scan_display_gen.sv - directed self-checking bench for scan_display_gen
module tb_scan_display_gen;

    localparam int DIGITS      = 8;
    localparam int DIV_BITS    = 4;
    localparam int BRIGHT_BITS = 2;
    localparam int FRAME       = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scan_display_gen_if #(.DIGITS(DIGITS), .DIV_BITS(DIV_BITS), .BRIGHT_BITS(BRIGHT_BITS)) bus ();

    scan_display_gen #(.DIGITS(DIGITS), .DIV_BITS(DIV_BITS), .BRIGHT_BITS(BRIGHT_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Posedges since reset release; output seen after edge n comes from stage-0 time n-1
    int n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    int checks = 0;
    int fails  = 0;

    logic [7:0] hexs [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    typedef struct {
        logic [31:0] data;
        logic [7:0]  dp;
        logic [7:0]  blank;
        logic        lz;
        logic [1:0]  br;
        int          w;
        int          c;
        logic [7:0]  seg;
        logic [3:0]  dig;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input int id, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    task automatic check_zero(input int id);
        chk("rst_which", id, 32'(bus.which), 0);
        chk("rst_seg",   id, 32'(bus.seg), 0);
        chk("rst_digit", id, 32'(bus.digit), 0);
        chk("rst_count", id, 32'(bus.count), 0);
        chk("rst_fd",    id, 32'(bus.frame_done), 0);
    endtask

    task automatic check_at(input int tn, input int ew, input int ec,
                            input logic [7:0] es, input logic [3:0] ed, input int id);
        int guard = 0;
        while (n < tn && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("cycle", id, n, tn);
        chk("which", id, 32'(bus.which), ew);
        chk("count", id, 32'(bus.count), ec);
        chk("seg",   id, 32'(bus.seg), 32'(es));
        chk("digit", id, 32'(bus.digit), 32'(ed));
    endtask

    task automatic set_in(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b,
                          input logic lz, input logic [1:0] br);
        bus.data        = d;
        bus.dp          = p;
        bus.blank       = b;
        bus.lz_suppress = lz;
        bus.bright      = br;
    endtask

    function automatic int next_latch();
        return (n / FRAME + 1) * FRAME;
    endfunction

    task automatic add(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b,
                       input logic lz, input logic [1:0] br, input int w, input int c,
                       input logic [7:0] s, input logic [3:0] g);
        vt.push_back('{d, p, b, lz, br, w, c, s, g});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int m, ew, L, L2;
        logic [31:0] seq_data;
        logic [7:0] es;
        logic [3:0] ed;

        seq_data = 32'hFEDC_BA98;
        for (int i = 0; i < 8; i++) add(32'hFEDC_BA98, 8'h00, 8'h00, 1'b0, 2'd3, i, 5, hexs[8+i], 4'(8+i));
        for (int i = 0; i < 8; i++) add(32'h7654_3210, 8'h00, 8'h00, 1'b0, 2'd3, i, 9, hexs[i], 4'(i));
        add(32'h0000_0450, 8'h00, 8'h00, 1'b1, 2'd3, 0, 5, 8'h3F, 4'h0);
        add(32'h0000_0450, 8'h00, 8'h00, 1'b1, 2'd3, 1, 5, 8'h6D, 4'h5);
        add(32'h0000_0450, 8'h00, 8'h00, 1'b1, 2'd3, 2, 5, 8'h66, 4'h4);
        add(32'h0000_0450, 8'h00, 8'h00, 1'b1, 2'd3, 3, 5, 8'h00, 4'h0);
        add(32'h0000_0450, 8'h80, 8'h00, 1'b1, 2'd3, 7, 5, 8'h00, 4'h0);
        add(32'h0000_0450, 8'h00, 8'h00, 1'b0, 2'd3, 3, 5, 8'h3F, 4'h0);
        add(32'h1000_0000, 8'h00, 8'h00, 1'b1, 2'd3, 3, 5, 8'h3F, 4'h0);
        add(32'h0000_0000, 8'h00, 8'h00, 1'b1, 2'd3, 0, 5, 8'h3F, 4'h0);
        add(32'h0000_0000, 8'h00, 8'h00, 1'b1, 2'd3, 1, 5, 8'h00, 4'h0);
        add(32'h0000_0000, 8'h00, 8'h00, 1'b1, 2'd3, 7, 5, 8'h00, 4'h0);
        add(32'h0000_0000, 8'h01, 8'h00, 1'b1, 2'd3, 0, 5, 8'hBF, 4'h0);
        add(32'h0000_0000, 8'h00, 8'h00, 1'b0, 2'd3, 5, 5, 8'h3F, 4'h0);
        add(32'h7654_3210, 8'h04, 8'h02, 1'b0, 2'd3, 2, 5, 8'hDB, 4'h2);
        add(32'h7654_3210, 8'h06, 8'h02, 1'b0, 2'd3, 1, 5, 8'h00, 4'h1);
        add(32'h7654_3210, 8'h04, 8'h02, 1'b0, 2'd3, 0, 5, 8'h3F, 4'h0);
        add(32'h7654_3210, 8'h00, 8'h00, 1'b0, 2'd1, 4, 0, 8'h66, 4'h4);
        add(32'h7654_3210, 8'h00, 8'h00, 1'b0, 2'd1, 4, 7, 8'h66, 4'h4);
        add(32'h7654_3210, 8'h00, 8'h00, 1'b0, 2'd1, 4, 8, 8'h00, 4'h4);
        add(32'h7654_3210, 8'h00, 8'h00, 1'b0, 2'd1, 4, 15, 8'h00, 4'h4);
        add(32'h7654_3210, 8'h00, 8'h00, 1'b0, 2'd0, 5, 3, 8'h6D, 4'h5);
        add(32'h7654_3210, 8'h00, 8'h00, 1'b0, 2'd0, 5, 4, 8'h00, 4'h5);
        add(32'h7654_3210, 8'h00, 8'h00, 1'b0, 2'd2, 6, 11, 8'h7D, 4'h6);
        add(32'h7654_3210, 8'h00, 8'h00, 1'b0, 2'd2, 6, 12, 8'h00, 4'h6);

        // Reset state, then the first two frames cycle by cycle
        set_in(seq_data, 8'h00, 8'h00, 1'b0, 2'd3);
        repeat (3) @(negedge clk);
        check_zero(0);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            m  = k - 1;
            ew = (m / 16) % 8;
            es = (k == 1) ? 8'h3F : hexs[seq_data[4*ew +: 4]];
            ed = (k == 1) ? 4'h0 : seq_data[4*ew +: 4];
            chk("seq_which", k, 32'(bus.which), ew);
            chk("seq_count", k, 32'(bus.count), m % 16);
            chk("seq_seg",   k, 32'(bus.seg), 32'(es));
            chk("seq_digit", k, 32'(bus.digit), 32'(ed));
            chk("seq_fd",    k, 32'(bus.frame_done), (m > 0 && m % FRAME == 0) ? 1 : 0);
            if (bus.frame_done) pulses++;
        end
        chk("fd_total", 0, pulses, 2);

        // Data change at which=3 only takes effect from the next frame
        L = next_latch();
        check_at(L + 48 + 1, 3, 0, 8'h7C, 4'hB, 100);
        bus.data = 32'h7654_3210;
        check_at(L + 64 + 5 + 1, 4, 5, 8'h39, 4'hC, 101);
        check_at(L + 112 + 5 + 1, 7, 5, 8'h71, 4'hF, 102);
        L2 = L + FRAME;
        check_at(L2 + 5 + 1, 0, 5, 8'h3F, 4'h0, 103);
        check_at(L2 + 64 + 5 + 1, 4, 5, 8'h66, 4'h4, 104);

        foreach (vt[i]) begin
            set_in(vt[i].data, vt[i].dp, vt[i].blank, vt[i].lz, vt[i].br);
            L = next_latch();
            check_at(L + 16 * vt[i].w + vt[i].c + 1, vt[i].w, vt[i].c, vt[i].seg, vt[i].dig, 200 + i);
        end

        // Reset asserted mid-frame at which=5
        set_in(32'h7654_3210, 8'h00, 8'h00, 1'b0, 2'd3);
        L = next_latch();
        check_at(L + 80 + 2 + 1, 5, 2, 8'h6D, 4'h5, 300);
        rst_n = 1'b0;
        #1;
        check_zero(301);
        bus.data = 32'h1357_9BDF;
        repeat (3) @(negedge clk);
        check_zero(302);
        rst_n = 1'b1;
        check_at(1, 0, 0, 8'h3F, 4'h0, 303);
        check_at(6, 0, 5, 8'h71, 4'hF, 304);
        check_at(16 + 5 + 1, 1, 5, 8'h5E, 4'hD, 305);
        check_at(112 + 5 + 1, 7, 5, 8'h06, 4'h1, 306);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/scan_display_gen.md
Name: scan_display_gen

Overview:
- Parametrised successor to the 8-digit hex seven-segment scan display.
- Time-multiplexes DIGITS hex digits onto one shared 8-bit segment bus, selected by `which`.
- Adds frame-synchronous data latching (no tearing), per-digit decimal point and blanking, leading-zero suppression, PWM brightness and a frame-done pulse.
- Sits between the CPU/debug data path and the board's seven-segment pins.

Parameters:
- DIGITS, 8: number of multiplexed digits (2..16); `data` width is 4*DIGITS.
- DIV_BITS, 11: scan divider width; digit dwell time is 2^DIV_BITS clk cycles.
- BRIGHT_BITS, 3: brightness resolution (1..DIV_BITS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data  in  4*DIGITS  hex nibbles; digit i = data[4i+3:4i]
- dp  in  DIGITS  decimal point enable per digit
- blank  in  DIGITS  force digit i dark
- lz_suppress  in  1  enable leading-zero suppression
- bright  in  BRIGHT_BITS  duty level; all-ones = 100%
- which  out  max(1,$clog2(DIGITS))  active digit index
- seg  out  8  segments, active-high: seg[7]=dp, seg[6:0]=g..a
- digit  out  4  nibble currently shown (debug)
- count  out  DIV_BITS  scan divider value (debug)
- frame_done  out  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (async assert, sync release): internal cnt=0, idx=0, snapshot=0, load_pend=1; outputs which=0, digit=0, seg=8'h00, count=0, frame_done=0.
- Stage 0 (internal):
  - cnt increments every clk and wraps 2^DIV_BITS-1 -> 0.
  - On cnt wrap, idx advances; at idx==DIGITS-1 it wraps to 0 (non-power-of-2 DIGITS supported).
- Snapshot: data/dp/blank are latched into shadow registers when either
  - load_pend=1 (first cycle after reset; load_pend then clears), or
  - the cycle in which idx wraps DIGITS-1 -> 0.
- Inputs changing mid-frame never affect the current frame.
- Stage 1 (output registers): which, count, digit and seg register stage-0 values, giving a fixed 1-cycle latency. All four outputs are mutually consistent in every cycle.
- Segment decode:
  - Standard hex table 0..F: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - seg[7] = shadow dp[idx].
- Leading-zero suppression: when lz_suppress=1, digit i (i>0) is dark if its nibble and all higher nibbles are 0. Digit 0 is never suppressed, so all zeros displays "0". lz_suppress is sampled live, not snapshotted.
- Blank: shadow blank[idx]=1 forces seg=8'h00, including dp.
- Brightness: segments are enabled only while cnt[DIV_BITS-1 -: BRIGHT_BITS] <= bright. Otherwise seg=8'h00.
  - `digit` and `which` are unaffected by brightness.
  - bright=0 gives a 1/2^BRIGHT_BITS duty cycle; there is no fully-off level (use blank for off).
- frame_done: registered; asserts for exactly one cycle, aligned with the output cycle where which goes DIGITS-1 -> 0.
- Reset mid-frame: everything returns to reset values immediately; the first post-reset frame re-latches inputs.

Decomposition:
- Package scan_display_pkg: HEX7SEG constant table (16 x 7 bits), SEG_OFF = 8'h00, and a width helper for the `which` port.
- Sub-module hex7seg_decoder: combinational nibble -> 7-bit lookup using the package table.
- All counters, snapshot, suppression and PWM logic live in the top module.

Test Plan (DIGITS=8, DIV_BITS=4, BRIGHT_BITS=2 for speed):
- Reset then data=32'hFEDC_BA98, bright=3 -> which cycles 0..7, each held for 16 clks; seg sequence 7F,6F,77,7C,39,5E,79,71; frame_done pulses once every 128 clks.
- Change data to 32'h7654_3210 mid-frame (which=3) -> remaining digits of that frame still show FEDC...; the next frame shows 3F,06,5B,4F,66,6D,7D,07.
- data=32'h0000_0450, lz_suppress=1 -> digits 3..7 seg=00; digits 0..2 show 3F,6D,66. data=0 -> only digit 0 shows 3F.
- dp=8'h04, blank=8'h02 -> digit 2 seg has bit7 set; digit 1 seg=00 regardless of data/dp.
- bright=1 -> within each 16-clk dwell, seg is lit for cnt 0..7 and 00 for cnt 8..15; which/digit are unchanged.
- Assert rst_n low at which=5 for 3 clks -> outputs immediately 0; after release, which restarts at 0 and the latest data is shown in the first frame.
